imm_ext_pipe: RTL



---
 rtl/imm_ext_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: two-stage registered immediate extender and branch-target adder.
//   Stage A extends the raw immediate per mode, pre-shifts the branch offset and
//   captures pc4. Stage B adds the offset to pc4 and drives every output.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          request handshake (in_ready is combinational)
//   in_imm, in_mode, in_pc4    raw immediate, extension mode, PC+4
//   flush                      squash everything in flight
//   out_valid/out_ready        result handshake
//   out_imm, out_off           extended immediate, offset (out_imm << OFF_SHIFT)
//   out_target, out_carry      in_pc4 + out_off (wrapped) and its carry-out
module imm_ext_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned OFF_SHIFT = 2,
    parameter int unsigned SHAMT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_off,
    output logic [DATA_W-1:0] out_target,
    output logic              out_carry
);

    localparam int unsigned PAD_W   = DATA_W - IMM_W;
    localparam int unsigned SPAD_W  = DATA_W - SHAMT_W;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_LUI   = 2'b10;
    localparam logic [1:0] MODE_SHAMT = 2'b11;

    // Stage A state
    logic              a_valid;
    logic [DATA_W-1:0] a_imm;
    logic [DATA_W-1:0] a_off;
    logic [DATA_W-1:0] a_pc4;

    logic              b_adv;
    logic              a_to_b;
    logic              accept;
    logic [DATA_W-1:0] ext_c;
    logic [DATA_W-1:0] off_c;
    logic [DATA_W:0]   sum_c;

    // Handshake: B frees when empty or drained; A frees when it moves into B
    assign b_adv    = !out_valid || out_ready;
    assign a_to_b   = a_valid && b_adv;
    assign in_ready = rst_n && !flush && (!a_valid || b_adv);
    assign accept   = in_valid && in_ready;

    // Immediate extension per mode
    always_comb begin
        ext_c = '0;
        case (in_mode)
            MODE_ZERO:  ext_c = {{PAD_W{1'b0}}, in_imm};
            MODE_SIGN:  ext_c = {{PAD_W{in_imm[IMM_W-1]}}, in_imm};
            MODE_LUI:   ext_c = {in_imm, {PAD_W{1'b0}}};
            MODE_SHAMT: ext_c = {{SPAD_W{1'b0}}, in_imm[SHAMT_W-1:0]};
            default:    ext_c = '0;
        endcase
    end

    assign off_c = ext_c << OFF_SHIFT;

    // One extra bit keeps the carry-out of the target addition
    assign sum_c = {1'b0, a_off} + {1'b0, a_pc4};

    // Pipeline registers; reset dominates flush, flush dominates handshakes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid    <= 1'b0;
            a_imm      <= '0;
            a_off      <= '0;
            a_pc4      <= '0;
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_off    <= '0;
            out_target <= '0;
            out_carry  <= 1'b0;
        end else begin
            if (flush) begin
                a_valid   <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                a_valid <= accept || (a_valid && !b_adv);
                if (b_adv) begin
                    out_valid <= a_valid;
                end
            end

            if (accept) begin
                a_imm <= ext_c;
                a_off <= off_c;
                a_pc4 <= in_pc4;
            end

            // Data may go stale under flush; only the valid bits matter then
            if (a_to_b && !flush) begin
                out_imm    <= a_imm;
                out_off    <= a_off;
                out_target <= sum_c[DATA_W-1:0];
                out_carry  <= sum_c[DATA_W];
            end
        end
    end

endmodule
